// File: rtl/spi_fsm_pkg.sv
// spi_pkg: shared state encoding, frame width and R/W bit meaning for the SPI memory controller
package spi_pkg;
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      GET_ADDR    = 3'd1,
      GOT_ADDR    = 3'd2,
      READ_LOAD   = 3'd3,
      READ_SHIFT  = 3'd4,
      WRITE_SHIFT = 3'd5,
      WRITE_STORE = 3'd6,
      DONE        = 3'd7
   } state_t;
   localparam int SPI_WORD_WIDTH = 8;
   localparam logic SPI_READ = 1'b1;
   localparam logic SPI_WRITE = 1'b0;
endpackage

// File: rtl/spi_fsm_if.sv
// spi_fsm_if: conditioned SPI inputs and shift-register/memory/MISO strobes of the transaction controller
interface spi_fsm_if;
   logic cs_n;
   logic sclk_posedge;
   logic rw_bit;
   logic sr_we;
   logic addr_we;
   logic dm_we;
   logic miso_buff_en;
   logic busy;
   modport master (
      output cs_n, sclk_posedge, rw_bit,
      input  sr_we, addr_we, dm_we, miso_buff_en, busy
   );
   modport slave (
      input  cs_n, sclk_posedge, rw_bit,
      output sr_we, addr_we, dm_we, miso_buff_en, busy
   );
endinterface

// File: rtl/spi_fsm_bitcounter.sv
// spi_bitcounter: sclk edge counter with a combinational last-bit flag
module spi_bitcounter
   import spi_pkg::*;
#(
   parameter int WORD_WIDTH = SPI_WORD_WIDTH,
   parameter int CNT_WIDTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic [CNT_WIDTH-1:0] count,
   output logic full
);
   assign full = inc && count == CNT_WIDTH'(WORD_WIDTH - 1);
   always_ff @(posedge clk)
      if (!rst_n || clear) count <= '0;
      else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI memory transaction controller decoding address+R/W then one data byte
module spi_fsm
   import spi_pkg::*;
#(
   parameter int WORD_WIDTH = SPI_WORD_WIDTH,
   parameter int CNT_WIDTH = 4
) (
   input logic clk,
   input logic rst_n,
   spi_fsm_if.slave bus
);
   state_t state, nextState;
   logic countInc, countClear, countFull;
   logic [CNT_WIDTH-1:0] count;
   if (WORD_WIDTH < 2 || (1 << CNT_WIDTH) <= WORD_WIDTH) begin : gBadParams
      $error("spi_fsm: WORD_WIDTH must be >= 2 and fit in CNT_WIDTH bits");
   end
   // only shift phases count edges; any state change restarts the count
   assign countInc = bus.sclk_posedge && (state inside {GET_ADDR, READ_SHIFT, WRITE_SHIFT});
   assign countClear = state == IDLE || nextState != state;
   spi_bitcounter #(.WORD_WIDTH(WORD_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bitCounter (
      .clk(clk),
      .rst_n(rst_n),
      .clear(countClear),
      .inc(countInc),
      .count(count),
      .full(countFull)
   );
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= nextState;
   // chip-select release aborts from anywhere and outranks every other transition
   always_comb begin
      nextState = state;
      if (state != IDLE && bus.cs_n) nextState = IDLE;
      else
         case (state)
            IDLE:        nextState = bus.cs_n ? IDLE : GET_ADDR;
            GET_ADDR:    nextState = countFull ? GOT_ADDR : GET_ADDR;
            GOT_ADDR:    nextState = bus.rw_bit == SPI_READ ? READ_LOAD : WRITE_SHIFT;
            READ_LOAD:   nextState = READ_SHIFT;
            READ_SHIFT:  nextState = countFull ? DONE : READ_SHIFT;
            WRITE_SHIFT: nextState = countFull ? WRITE_STORE : WRITE_SHIFT;
            WRITE_STORE: nextState = DONE;
            default:     nextState = DONE;
         endcase
   end
   always_comb begin
      bus.addr_we = state == GOT_ADDR;
      bus.sr_we = state == READ_LOAD;
      bus.miso_buff_en = state == READ_SHIFT;
      bus.dm_we = state == WRITE_STORE;
      bus.busy = state != IDLE;
   end
   assert property (@(posedge clk) disable iff (!rst_n) count < CNT_WIDTH'(WORD_WIDTH));
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed and randomized SPI frames checked every cycle against an edge-count model
module tb_spi_fsm;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   bit rwDrive = 1'b0;
   bit noisyRw = 1'b0;
   bit mActive = 1'b0;
   bit mRead = 1'b0;
   int mEdges = 0;
   int mEv = -1;
   int mDone = -1;
   spi_fsm_if bus ();
   spi_fsm #(.WORD_WIDTH(W), .CNT_WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask
   // mEv counts cycles since the address byte completed; mDone cycles since the data byte completed
   task automatic modelStep(input bit cs, input bit sc, input bit rw, input bit rs);
      if (!rs || (mActive && cs)) mActive = 1'b0;
      else if (!mActive) begin
         if (!cs) begin
            mActive = 1'b1;
            mEdges = 0;
            mEv = -1;
            mDone = -1;
            mRead = 1'b0;
         end
      end else if (mEdges < W) begin
         if (sc) begin
            mEdges++;
            if (mEdges == W) mEv = 0;
         end
      end else begin
         mEv++;
         if (mEv == 1) mRead = rw;
         if (mDone >= 0) mDone++;
         else if (sc && mEv >= (mRead ? 3 : 2)) begin
            mEdges++;
            if (mEdges == 2 * W) mDone = 0;
         end
      end
   endtask
   task automatic step(input bit cs, input bit sc, input bit rs = 1'b1);
      bit rw;
      rw = noisyRw ? 1'($urandom_range(0, 1)) : rwDrive;
      bus.cs_n = cs;
      bus.sclk_posedge = sc;
      bus.rw_bit = rw;
      rst_n = rs;
      @(posedge clk);
      modelStep(cs, sc, rw, rs);
      @(negedge clk);
      check("busy", bus.busy, mActive);
      check("addr_we", bus.addr_we, mActive && mEdges == W && mEv == 0);
      check("sr_we", bus.sr_we, mActive && mRead && mEv == 1);
      check("miso_buff_en", bus.miso_buff_en, mActive && mRead && mEv >= 2 && mEdges < 2 * W);
      check("dm_we", bus.dm_we, mActive && !mRead && mDone == 0);
   endtask
   task automatic edges(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1);
         repeat ($urandom_range(2, 4)) step(1'b0, 1'b0);
      end
   endtask
   task automatic frame(input bit rw, input int abortAt, input int idle);
      rwDrive = rw;
      step(1'b0, 1'b0);
      edges(abortAt == 0 ? 2 * W : abortAt);
      if (abortAt == 0) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0);
      repeat (idle) step(1'b1, 1'b0);
   endtask
   initial begin
      bus.cs_n = 1'b1;
      bus.sclk_posedge = 1'b0;
      bus.rw_bit = 1'b0;
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0);
      frame(1'b0, 0, 2);
      frame(1'b1, 0, 2);
      frame(1'b0, W + 5, 2);
      frame(1'b0, 0, 2);
      // frame opens with an edge that must not count, and a 9th edge lands in GOT_ADDR
      rwDrive = 1'b0;
      step(1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0);
      edges(W - 1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0);
      edges(W);
      repeat (2) step(1'b1, 1'b0);
      rwDrive = 1'b1;
      step(1'b0, 1'b0);
      edges(W + 3);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0);
      edges(2 * W);
      repeat (2) step(1'b1, 1'b0);
      frame(1'b0, 0, 1);
      frame(1'b0, 0, 1);
      frame(1'b1, 0, 1);
      noisyRw = 1'b1;
      for (int f = 0; f < 40; f++)
         frame(1'b0, $urandom_range(0, 3) == 0 ? $urandom_range(1, 2 * W - 1) : 0, $urandom_range(1, 3));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/spi_fsm.md
# spi_fsm

Transaction controller for the SPI memory peripheral. It consumes the conditioned chip-select and sclk-edge pulses plus the shift register's latest bit, counts bits, and decodes each frame: 7-bit address plus R/W bit, then one data byte. It sequences the strobes that drive the shift register parallel load, the address latch, the data-memory write enable and the MISO tri-state buffer.

## Interface

Parameters:
- `WORD_WIDTH`, 8, bits per address phase and per data phase; must be ≥2.
- `CNT_WIDTH`, 4, bit-counter width; must satisfy 2^CNT_WIDTH > WORD_WIDTH.

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cs_n` in 1: conditioned chip select, active low.
- `sclk_posedge` in 1: one-`clk` pulse per conditioned sclk rising edge.
- `rw_bit` in 1: shift register `parallelDataOut[0]`; 1 = read, 0 = write.
- `sr_we` out 1: shift register parallel-load strobe.
- `addr_we` out 1: address latch enable.
- `dm_we` out 1: data-memory write enable.
- `miso_buff_en` out 1: MISO output-buffer enable.
- `busy` out 1: high whenever the state is not IDLE.

## Operation

States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_STORE, DONE.

- IDLE: counter = 0. `cs_n`=0 → GET_ADDR. An `sclk_posedge` in the same cycle is not counted.
- GET_ADDR: counter increments on each `sclk_posedge`. When the WORD_WIDTH-th edge arrives, go to GOT_ADDR and clear the counter.
- GOT_ADDR (1 cycle): `addr_we`=1. Sample `rw_bit`: 1 → READ_LOAD, 0 → WRITE_SHIFT.
- READ_LOAD (1 cycle): `sr_we`=1, then → READ_SHIFT.
- READ_SHIFT: `miso_buff_en`=1. Count WORD_WIDTH edges, then → DONE.
- WRITE_SHIFT: count WORD_WIDTH edges, then → WRITE_STORE.
- WRITE_STORE (1 cycle): `dm_we`=1, then → DONE.
- DONE: all strobes 0. Hold until `cs_n`=1.
- Abort: `cs_n`=1 in any non-IDLE state → IDLE on the next edge. This has priority over every other transition.
  - No `dm_we` pulse is issued for a write aborted before WRITE_STORE.
  - If the abort coincides with GOT_ADDR or WRITE_STORE, that cycle's strobe still asserts, because strobes are Moore outputs.
- Extra `sclk_posedge` pulses in GOT_ADDR, READ_LOAD, WRITE_STORE or DONE are ignored and not counted.
- Counter never wraps. It clears on every phase transition and on return to IDLE.

## Timing

- Outputs are pure functions of the registered state (Moore). They change one `clk` after the causing input.
- Reset: state=IDLE, counter=0, and `sr_we`, `addr_we`, `dm_we`, `miso_buff_en`, `busy` all 0.
- Reset mid-transaction behaves like an abort, including a suppressed write.
- `addr_we` pulse comes exactly 1 cycle after the cycle holding the 8th address `sclk_posedge`.
- `sr_we` comes 1 cycle after `addr_we`.
- `miso_buff_en` rises 2 cycles after `addr_we`. It falls 1 cycle after the 8th data edge or after `cs_n` rises.
- `dm_we` comes 1 cycle after the cycle holding the 8th data edge.
- Each strobe is exactly one `clk` wide.
- `sclk_posedge` pulses are at least 3 `clk` apart, which is guaranteed by the input conditioners. The FSM does not buffer edges.

## Structure

- Shared package `spi_pkg` holds:
  - the state encoding constants (3-bit binary, IDLE=0);
  - the `WORD_WIDTH` default;
  - the R/W bit meaning constants `SPI_READ`=1 and `SPI_WRITE`=0.
- One sub-module, `spi_bitcounter` (~30 lines), provides:
  - inputs: `clk`, `rst_n`, `clear`, `inc`;
  - output: `count`;
  - output: `full`, asserted combinationally when `count == WORD_WIDTH-1 && inc`.
- The FSM is a single registered state, a next-state block and an output decode.

## Test plan

- Write frame: 8 edges with `rw_bit`=0 at GOT_ADDR, then 8 edges → `addr_we` 1 cycle, `dm_we` 1 cycle after edge 16, `miso_buff_en` stays 0, `cs_n`↑ → IDLE and `busy`=0.
- Read frame: 8 edges with `rw_bit`=1 → `addr_we`, then `sr_we` the next cycle, then `miso_buff_en`=1 through edge 16 and 0 on the following cycle.
- Abort write: `cs_n`↑ after 5 data edges → IDLE next cycle and `dm_we` never pulses. A fresh frame then completes normally with the counter starting at 0.
- Coincidence: `cs_n`↓ in the same cycle as a `sclk_posedge` → that edge is ignored and `addr_we` waits for 8 further edges. A 9th edge during GOT_ADDR is not counted.
- Reset: `rst_n`=0 for 1 cycle during READ_SHIFT → all outputs 0 the next cycle and state IDLE. Holding `cs_n`=0 restarts GET_ADDR after reset releases.
- Back-to-back: two write frames separated by a single `clk` of `cs_n`=1 → two `dm_we` pulses and two `addr_we` pulses, no lost edges.
